// File: rtl/ga20_sample_fetch.sv
// GA20 sample fetch: line-buffered byte reads from the 16-bit sound ROM,
// with a low-priority uncached aux port sharing the same memory port.
module ga20_sample_fetch #(
    parameter int LINES  = 4,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_rd,
    input  logic [ADDR_W-1:0] sample_addr,
    output logic              sample_valid,
    output logic [7:0]        sample_din,
    input  logic              aux_rd,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_valid,
    output logic [7:0]        aux_data,
    input  logic              inval,
    output logic              mem_rd,
    output logic [ADDR_W-2:0] mem_addr,
    input  logic              mem_ready,
    input  logic [15:0]       mem_data
);
    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_W - 3;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, FILL_REQ, FILL_WAIT, AUX_REQ, AUX_WAIT
    } state_t;

    state_t            state;
    logic [TW-1:0]     tags [LINES];
    logic [7:0]        data [LINES][8];
    logic [LINES-1:0]  valid;
    logic [IW-1:0]     rptr;
    logic [IW-1:0]     victim;
    logic [IW-1:0]     hit_idx;
    logic [1:0]        fidx;
    logic              ga_pend;
    logic              aux_pend;
    logic              inval_seen;
    logic              aux_sel;
    logic              hit;
    logic [ADDR_W-1:0] ga_addr;
    logic [ADDR_W-1:0] aux_addr_q;
    logic [TW-1:0]     ga_tag;

    assign ga_tag = ga_addr[ADDR_W-1:3];

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < LINES; i++) begin
            if (valid[i] && tags[i] == ga_tag) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            valid        <= '0;
            rptr         <= '0;
            victim       <= '0;
            fidx         <= '0;
            ga_pend      <= 1'b0;
            aux_pend     <= 1'b0;
            inval_seen   <= 1'b0;
            aux_sel      <= 1'b0;
            ga_addr      <= '0;
            aux_addr_q   <= '0;
            sample_valid <= 1'b0;
            sample_din   <= '0;
            aux_valid    <= 1'b0;
            aux_data     <= '0;
            mem_rd       <= 1'b0;
            mem_addr     <= '0;
            for (int i = 0; i < LINES; i++) tags[i] <= '0;
        end else begin
            mem_rd    <= 1'b0;
            aux_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ga_pend || sample_rd) state <= LOOKUP;
                    else if (aux_pend)        state <= AUX_REQ;
                end
                LOOKUP: begin
                    if (hit) begin
                        sample_din   <= data[hit_idx][ga_addr[2:0]];
                        sample_valid <= 1'b1;
                        ga_pend      <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        victim       <= rptr;
                        valid[rptr]  <= 1'b0;
                        tags[rptr]   <= ga_tag;
                        fidx         <= '0;
                        inval_seen   <= 1'b0;
                        state        <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    mem_rd   <= 1'b1;
                    mem_addr <= {tags[victim], fidx};
                    state    <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (mem_ready) begin
                        if (fidx == 2'd3) begin
                            if (!inval_seen) valid[victim] <= 1'b1;
                            rptr  <= rptr + 1'b1;
                            state <= LOOKUP;
                        end else begin
                            fidx  <= fidx + 2'd1;
                            state <= FILL_REQ;
                        end
                    end
                end
                AUX_REQ: begin
                    mem_rd   <= 1'b1;
                    mem_addr <= aux_addr_q[ADDR_W-1:1];
                    aux_sel  <= aux_addr_q[0];
                    state    <= AUX_WAIT;
                end
                AUX_WAIT: begin
                    if (mem_ready) begin
                        aux_data  <= aux_sel ? mem_data[15:8] : mem_data[7:0];
                        aux_valid <= 1'b1;
                        aux_pend  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // an invalidate during a fill must keep that line from going valid
            if (inval && (state == FILL_REQ || state == FILL_WAIT))
                inval_seen <= 1'b1;
            if (inval) valid <= '0;

            if (sample_rd) begin
                ga_pend      <= 1'b1;
                ga_addr      <= sample_addr;
                sample_valid <= 1'b0;
            end
            if (aux_rd) begin
                aux_pend   <= 1'b1;
                aux_addr_q <= aux_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL_WAIT && mem_ready) begin
            data[victim][{fidx, 1'b0}] <= mem_data[7:0];
            data[victim][{fidx, 1'b1}] <= mem_data[15:8];
        end
    end

endmodule
